tdm_demux: RTL and testbench
============================

TDM_DEMUX -- requirements
Module: tdm_demux

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset.
REQ-002 Parameter NUM_CH, default 2, SHALL be the number of time slots (channels) per frame; legal range 2..16.
REQ-003 Parameter DATA_W, default 1, SHALL be the bit width of one slot.
REQ-004 clk  input  1  SHALL be the single clock; all logic is on its rising edge.
REQ-005 rst  input  1  SHALL be the synchronous, active-high reset.
REQ-006 en  input  1  SHALL be the slot strobe; din and sync are sampled only when en=1.
REQ-007 sync  input  1  SHALL be the frame marker, high with en on slot 0 only.
REQ-008 din  input  DATA_W  SHALL be the multiplexed slot data.
REQ-009 dout  output  NUM_CH*DATA_W  SHALL be the recovered channels; channel k occupies bits [k*DATA_W +: DATA_W].
REQ-010 frame_valid  output  1  SHALL pulse for one cycle when dout updates.
REQ-011 locked  output  1  SHALL be high while the FSM is in LOCKED.
REQ-012 sync_err  output  1  SHALL pulse for one cycle on a framing error.

Function
REQ-013 The FSM SHALL have exactly two states, HUNT and LOCKED.
REQ-014 In HUNT, en=1 with sync=0 SHALL be ignored.
REQ-015 In HUNT, en=1 with sync=1 SHALL store din into shadow slot 0, set slot counter to 1 and move to LOCKED.
REQ-016 In LOCKED, en=1 with sync=0 and counter!=0 SHALL store din into shadow slot[counter] and increment the counter.
REQ-017 When the stored slot is NUM_CH-1, dout SHALL be loaded with the shadow slots plus the current din on that same edge, frame_valid SHALL be 1 in the following cycle, and the counter SHALL wrap to 0.
REQ-018 Latency from the last-slot en sample to dout/frame_valid SHALL be exactly one clock.
REQ-019 In LOCKED, en=1 with sync=1 and counter=0 SHALL store din into slot 0 and set the counter to 1 (normal frame start).
REQ-020 In LOCKED, en=1 with sync=1 and counter!=0 (early sync) SHALL pulse sync_err, discard the partial frame, store din as slot 0, set the counter to 1 and stay LOCKED; dout SHALL NOT change.
REQ-021 In LOCKED, en=1 with sync=0 and counter=0 (missing sync) SHALL pulse sync_err, discard din and go to HUNT.
REQ-022 sync with en=0 SHALL be ignored in all states.
REQ-023 Cycles with en=0 SHALL hold counter, shadow and dout unchanged; back-to-back en=1 every cycle SHALL be supported.
REQ-024 dout SHALL hold its last complete frame until the next complete frame; partial frames never reach dout.
REQ-025 The counter SHALL be $clog2(NUM_CH) bits wide and SHALL never exceed NUM_CH-1.

Reset
REQ-026 On rst=1, state SHALL be HUNT, counter 0, shadow 0, dout 0, frame_valid 0, locked 0 and sync_err 0 at the next edge.
REQ-027 rst SHALL override en/sync in the same cycle; a frame in progress SHALL be discarded without frame_valid or sync_err.

Structure
REQ-028 Package tdm_pkg SHALL hold the state enum (HUNT, LOCKED) and the default NUM_CH/DATA_W constants.
REQ-029 The slot counter with wrap and load-to-1 SHALL be one sub-module, tdm_slot_counter.
REQ-030 All outputs SHALL be registered.

Verification
REQ-031 NUM_CH=2, DATA_W=1: en every cycle, (sync,din)=(1,1),(0,0) -> locked=1 after first edge; dout=2'b01 and frame_valid=1 one cycle after the second sample.
REQ-032 NUM_CH=4, DATA_W=8: slots 0x11,0x22,0x33,0x44 with en gaps of 3 cycles -> dout=0x44332211 once; frame_valid exactly one cycle.
REQ-033 NUM_CH=4: sync on slot 2 -> sync_err pulse; previous dout held; next 4 slots AA,BB,CC,DD starting at that sync produce dout=0xDDCCBBAA.
REQ-034 NUM_CH=2, locked: slot 0 arrives with sync=0 -> sync_err pulse, locked=0; en pulses without sync ignored; the next sync relocks.
REQ-035 rst asserted mid-frame (after slot 1 of 4) -> all outputs 0 next cycle, no frame_valid; a new full frame decodes correctly.
REQ-036 en=0 with sync=1 and din toggling for 10 cycles in HUNT -> locked stays 0 and dout stays 0.

Source files
------------

// File: rtl/tdm_pkg.sv
// tdm_pkg: shared FSM state type and default frame geometry for the TDM demultiplexer
package tdm_pkg;
  typedef enum logic {HUNT, LOCKED} state_t;
  localparam int NUM_CH_DEF = 2;
  localparam int DATA_W_DEF = 1;
endpackage

// File: rtl/tdm_slot_counter.sv
// tdm_slot_counter: slot index that wraps after NUM_CH-1 and loads 1 on frame start; in clk/rst/load_i/inc_i, out cnt_o
module tdm_slot_counter #(
  parameter int NUM_CH = 2
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      load_i,
  input  logic                      inc_i,
  output logic [$clog2(NUM_CH)-1:0] cnt_o
);
  localparam int CW = $clog2(NUM_CH);
  localparam logic [CW-1:0] LAST = CW'(NUM_CH - 1);
  logic [CW-1:0] cnt_q;
  always_ff @(posedge clk)
    if (rst) cnt_q <= '0;
    else if (load_i) cnt_q <= CW'(1);
    else if (inc_i) cnt_q <= cnt_q == LAST ? '0 : cnt_q + CW'(1);
  assign cnt_o = cnt_q;
endmodule

// File: rtl/tdm_demux.sv
// tdm_demux: frame-locking TDM demultiplexer; in clk/rst/en/sync/din, out dout (channel k at [k*DATA_W +: DATA_W])/frame_valid/locked/sync_err
module tdm_demux
  import tdm_pkg::*;
#(
  parameter int NUM_CH = NUM_CH_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     en,
  input  logic                     sync,
  input  logic [DATA_W-1:0]        din,
  output logic [NUM_CH*DATA_W-1:0] dout,
  output logic                     frame_valid,
  output logic                     locked,
  output logic                     sync_err
);
  localparam int CW = $clog2(NUM_CH);
  localparam logic [CW-1:0] LAST = CW'(NUM_CH - 1);
  state_t state_q;
  logic [CW-1:0] cnt;
  logic [NUM_CH*DATA_W-1:0] shadow_q, shadow_d, dout_q;
  logic fv_q, err_q, hunt, zero, start, early, data, miss, last;
  always_comb begin
    hunt = state_q == HUNT;
    zero = cnt == '0;
    start = en & sync & (hunt | zero);
    early = en & sync & !hunt & !zero;
    data = en & !sync & !hunt & !zero;
    miss = en & !sync & !hunt & zero;
    last = data & (cnt == LAST);
    shadow_d = shadow_q;
    if (start | early) shadow_d[0 +: DATA_W] = din;
    else if (data) shadow_d[int'(cnt)*DATA_W +: DATA_W] = din;
  end
  tdm_slot_counter #(.NUM_CH(NUM_CH)) u_cnt (
    .clk    (clk),
    .rst    (rst),
    .load_i (start | early),
    .inc_i  (data),
    .cnt_o  (cnt)
  );
  always_ff @(posedge clk)
    if (rst) begin
      state_q  <= HUNT;
      shadow_q <= '0;
      dout_q   <= '0;
      fv_q     <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= start ? LOCKED : miss ? HUNT : state_q;
      shadow_q <= shadow_d;
      dout_q   <= last ? shadow_d : dout_q;
      fv_q     <= last;
      err_q    <= early | miss;
    end
  assign dout        = dout_q;
  assign frame_valid = fv_q;
  assign locked      = state_q == LOCKED;
  assign sync_err    = err_q;
endmodule

// File: tb/tb_tdm_demux.sv
// tb_tdm_demux: vector table plus scoreboard queue exercising a 4x8 and a 2x1 demultiplexer
module tb_tdm_demux;
  logic clk = 1'b0;
  logic rst = 1'b0;
  logic en4 = 1'b0, sync4 = 1'b0, en2 = 1'b0, sync2 = 1'b0, din2 = 1'b0;
  logic [7:0] din4 = '0;
  logic [31:0] dout4;
  logic [1:0] dout2;
  logic fv4, lk4, er4, fv2, lk2, er2;
  int total = 0;
  int passed = 0;
  always #5 clk = ~clk;
  tdm_demux #(.NUM_CH(4), .DATA_W(8)) u4 (
    .clk(clk), .rst(rst), .en(en4), .sync(sync4), .din(din4),
    .dout(dout4), .frame_valid(fv4), .locked(lk4), .sync_err(er4)
  );
  tdm_demux #(.NUM_CH(2), .DATA_W(1)) u2 (
    .clk(clk), .rst(rst), .en(en2), .sync(sync2), .din(din2),
    .dout(dout2), .frame_valid(fv2), .locked(lk2), .sync_err(er2)
  );
  typedef struct {
    bit d2;
    bit rst, en, sync;
    logic [7:0] din;
    bit locked, fv, err;
    logic [31:0] dout;
  } vec_t;
  vec_t tab[$];
  vec_t exp_q[$];
  function automatic vec_t mk(bit d2, bit r, bit e, bit s, logic [7:0] d,
                              bit lk, bit fv, bit er, logic [31:0] dout);
    vec_t v;
    v.d2 = d2; v.rst = r; v.en = e; v.sync = s; v.din = d;
    v.locked = lk; v.fv = fv; v.err = er; v.dout = dout;
    return v;
  endfunction
  task automatic chk(string n, int idx, logic [31:0] act, logic [31:0] req);
    total++;
    if (act === req) passed++;
    else $display("FAIL %s vec %0d: got %h required %h", n, idx, act, req);
  endtask
  task automatic run(input vec_t v, input int idx);
    vec_t e;
    rst = v.rst;
    en4 = 1'b0; sync4 = 1'b0; en2 = 1'b0; sync2 = 1'b0;
    if (v.d2) begin
      en2 = v.en; sync2 = v.sync; din2 = v.din[0];
    end else begin
      en4 = v.en; sync4 = v.sync; din4 = v.din;
    end
    exp_q.push_back(v);
    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    if (e.d2) begin
      chk("locked2", idx, {31'b0, lk2}, {31'b0, e.locked});
      chk("frame_valid2", idx, {31'b0, fv2}, {31'b0, e.fv});
      chk("sync_err2", idx, {31'b0, er2}, {31'b0, e.err});
      chk("dout2", idx, {30'b0, dout2}, e.dout);
    end else begin
      chk("locked4", idx, {31'b0, lk4}, {31'b0, e.locked});
      chk("frame_valid4", idx, {31'b0, fv4}, {31'b0, e.fv});
      chk("sync_err4", idx, {31'b0, er4}, {31'b0, e.err});
      chk("dout4", idx, dout4, e.dout);
    end
  endtask
  initial begin
    // 2 channels x 1 bit: basic lock, missing sync, relock
    tab.push_back(mk(1, 1, 0, 0, 8'h0, 0, 0, 0, 32'h0));
    tab.push_back(mk(1, 0, 1, 1, 8'h1, 1, 0, 0, 32'h0));
    tab.push_back(mk(1, 0, 1, 0, 8'h0, 1, 1, 0, 32'h1));
    tab.push_back(mk(1, 0, 1, 1, 8'h0, 1, 0, 0, 32'h1));
    tab.push_back(mk(1, 0, 1, 0, 8'h1, 1, 1, 0, 32'h2));
    tab.push_back(mk(1, 0, 1, 0, 8'h1, 0, 0, 1, 32'h2));
    tab.push_back(mk(1, 0, 1, 0, 8'h0, 0, 0, 0, 32'h2));
    tab.push_back(mk(1, 0, 1, 0, 8'h1, 0, 0, 0, 32'h2));
    tab.push_back(mk(1, 0, 1, 1, 8'h1, 1, 0, 0, 32'h2));
    tab.push_back(mk(1, 0, 1, 0, 8'h1, 1, 1, 0, 32'h3));
    // 4 channels x 8 bits: gapped frame
    tab.push_back(mk(0, 1, 0, 0, 8'h00, 0, 0, 0, 32'h0));
    tab.push_back(mk(0, 0, 1, 1, 8'h11, 1, 0, 0, 32'h0));
    for (int i = 0; i < 3; i++) tab.push_back(mk(0, 0, 0, 1, 8'hE0, 1, 0, 0, 32'h0));
    tab.push_back(mk(0, 0, 1, 0, 8'h22, 1, 0, 0, 32'h0));
    for (int i = 0; i < 3; i++) tab.push_back(mk(0, 0, 0, 0, 8'hE1, 1, 0, 0, 32'h0));
    tab.push_back(mk(0, 0, 1, 0, 8'h33, 1, 0, 0, 32'h0));
    for (int i = 0; i < 3; i++) tab.push_back(mk(0, 0, 0, 1, 8'hE2, 1, 0, 0, 32'h0));
    tab.push_back(mk(0, 0, 1, 0, 8'h44, 1, 1, 0, 32'h44332211));
    tab.push_back(mk(0, 0, 0, 0, 8'h00, 1, 0, 0, 32'h44332211));
    // early sync on slot 2 restarts the frame
    tab.push_back(mk(0, 0, 1, 1, 8'h55, 1, 0, 0, 32'h44332211));
    tab.push_back(mk(0, 0, 1, 0, 8'h66, 1, 0, 0, 32'h44332211));
    tab.push_back(mk(0, 0, 1, 1, 8'hAA, 1, 0, 1, 32'h44332211));
    tab.push_back(mk(0, 0, 1, 0, 8'hBB, 1, 0, 0, 32'h44332211));
    tab.push_back(mk(0, 0, 1, 0, 8'hCC, 1, 0, 0, 32'h44332211));
    tab.push_back(mk(0, 0, 1, 0, 8'hDD, 1, 1, 0, 32'hDDCCBBAA));
    tab.push_back(mk(0, 0, 0, 0, 8'h00, 1, 0, 0, 32'hDDCCBBAA));
    // missing sync drops to HUNT; unsynced and en-less strobes ignored
    tab.push_back(mk(0, 0, 1, 0, 8'h77, 0, 0, 1, 32'hDDCCBBAA));
    tab.push_back(mk(0, 0, 1, 0, 8'h88, 0, 0, 0, 32'hDDCCBBAA));
    tab.push_back(mk(0, 0, 0, 1, 8'h99, 0, 0, 0, 32'hDDCCBBAA));
    // reset mid-frame, then a fresh frame
    tab.push_back(mk(0, 0, 1, 1, 8'h01, 1, 0, 0, 32'hDDCCBBAA));
    tab.push_back(mk(0, 0, 1, 0, 8'h02, 1, 0, 0, 32'hDDCCBBAA));
    tab.push_back(mk(0, 1, 1, 0, 8'h03, 0, 0, 0, 32'h0));
    tab.push_back(mk(0, 0, 1, 0, 8'h04, 0, 0, 0, 32'h0));
    tab.push_back(mk(0, 0, 1, 1, 8'hA1, 1, 0, 0, 32'h0));
    tab.push_back(mk(0, 0, 1, 0, 8'hB2, 1, 0, 0, 32'h0));
    tab.push_back(mk(0, 0, 1, 0, 8'hC3, 1, 0, 0, 32'h0));
    tab.push_back(mk(0, 0, 1, 0, 8'hD4, 1, 1, 0, 32'hD4C3B2A1));
    tab.push_back(mk(0, 0, 0, 0, 8'h00, 1, 0, 0, 32'hD4C3B2A1));
    for (int i = 0; i < tab.size(); i++) run(tab[i], i);
    // sync held without en in HUNT must never lock
    run(mk(0, 1, 0, 0, 8'h00, 0, 0, 0, 32'h0), 100);
    for (int i = 0; i < 10; i++) begin
      logic [31:0] t;
      t = i;
      run(mk(0, 0, 0, 1, t[0] ? 8'hFF : 8'h00, 0, 0, 0, 32'h0), 101 + i);
    end
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
